clock_gen: RTL and testbench

- Programmable clock/strobe generator: the producing counterpart of clock_meter.
- Takes a frequency request in Hz, the same unit and 32-bit width that clock_meter reports.
- Synthesises a square wave and a matching one-cycle strobe at that frequency from clk_i, using a phase accumulator (NCO).
- Used to drive clock enables and test stimuli whose rate clock_meter can then measure in loopback.

---
 rtl/clock_gen_pkg.sv | 22 ++
 rtl/udiv_seq.sv | 62 ++++++
 rtl/clock_gen.sv | 99 +++++++++
 tb/tb_clock_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_gen_pkg.sv
// Shared types and constants for the clock_gen NCO strobe generator.
// hz_to_incr() is a reference helper for benches; the datapath uses udiv_seq.
package clock_gen_pkg;

    localparam int FREQ_WIDTH = 32;

    typedef enum logic [1:0] {IDLE, DIV, RUN} clock_gen_state_t;

    // floor (or round-to-nearest) of hz * 2^32 / clk_hz for a 32-bit accumulator
    function automatic logic [31:0] hz_to_incr(input logic [31:0] hz,
                                               input logic [31:0] clk_hz,
                                               input logic        round_en);
        logic [63:0] num;
        logic [63:0] quo;
        num = {hz, 32'd0};
        if (round_en)
            num = num + {33'd0, clk_hz[31:1]};
        quo = num / {32'd0, clk_hz};
        return quo[31:0];
    endfunction

endpackage

// File: rtl/udiv_seq.sv
// Sequential restoring divider, one quotient bit per cycle, Q_WIDTH cycles.
// Caller guarantees num_i[N_WIDTH-1:Q_WIDTH] < den_i (quotient fits Q_WIDTH).
module udiv_seq #(
    parameter int N_WIDTH = 64,
    parameter int D_WIDTH = 32,
    parameter int Q_WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [N_WIDTH-1:0] num_i,
    input  logic [D_WIDTH-1:0] den_i,
    output logic               done_o,
    output logic [Q_WIDTH-1:0] quotient_o
);
    localparam int RW = D_WIDTH + 1;
    localparam int CW = $clog2(Q_WIDTH + 1);

    logic [RW-1:0]      rem_q, rem_d, trial;
    logic [Q_WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               take;

    // quo_q doubles as the shift register feeding remaining numerator bits
    always_comb begin
        trial  = {rem_q[RW-2:0], quo_q[Q_WIDTH-1]};
        take   = (trial >= {1'b0, den_i});
        rem_d  = rem_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (start_i) begin
            rem_d = RW'(num_i[N_WIDTH-1:Q_WIDTH]);
            quo_d = num_i[Q_WIDTH-1:0];
            cnt_d = CW'(Q_WIDTH);
        end else if (cnt_q != '0) begin
            rem_d  = take ? (trial - {1'b0, den_i}) : trial;
            quo_d  = {quo_q[Q_WIDTH-2:0], take};
            cnt_d  = cnt_q - CW'(1);
            done_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/clock_gen.sv
// Programmable NCO square-wave / strobe generator driven by a Hz request.
// Build option: define CLOCK_GEN_ROUND_EN for round-to-nearest increments.
module clock_gen
    import clock_gen_pkg::*;
#(
    parameter int CLK_MHZ   = 100,
    parameter int ACC_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  a_rst_n_i,
    input  logic                  en_i,
    input  logic [FREQ_WIDTH-1:0] freq_val_i,
    input  logic                  freq_vld_i,
    output logic                  freq_rdy_o,
    output logic                  gen_clk_o,
    output logic                  gen_stb_o,
    output logic                  err_o
);
    localparam logic [FREQ_WIDTH-1:0] CLK_HZ  = FREQ_WIDTH'(CLK_MHZ * 1_000_000);
    localparam logic [FREQ_WIDTH-1:0] HALF_HZ = CLK_HZ >> 1;
    localparam int                    NUM_W   = FREQ_WIDTH + ACC_WIDTH;

    clock_gen_state_t     state_q, state_d;
    logic [ACC_WIDTH-1:0] incr_q, incr_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 err_q, err_d;
    logic                 clk_q, clk_d;
    logic                 stb_q, stb_d;

    logic                 xfer, in_range, div_start, div_done;
    logic [NUM_W-1:0]     div_num;
    logic [ACC_WIDTH-1:0] div_quot;

    assign freq_rdy_o = (state_q != DIV);
    assign xfer       = freq_vld_i & freq_rdy_o;
    assign in_range   = (freq_val_i <= HALF_HZ);
    assign div_start  = xfer & in_range;

`ifdef CLOCK_GEN_ROUND_EN
    assign div_num = {freq_val_i, {ACC_WIDTH{1'b0}}} + NUM_W'(HALF_HZ);
`else
    assign div_num = {freq_val_i, {ACC_WIDTH{1'b0}}};
`endif

    udiv_seq #(
        .N_WIDTH(NUM_W),
        .D_WIDTH(FREQ_WIDTH),
        .Q_WIDTH(ACC_WIDTH)
    ) u_div (
        .clk_i     (clk_i),
        .rst_n_i   (a_rst_n_i),
        .start_i   (div_start),
        .num_i     (div_num),
        .den_i     (CLK_HZ),
        .done_o    (div_done),
        .quotient_o(div_quot)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, RUN: if (div_start) state_d = DIV;
            DIV:       if (div_done)  state_d = RUN;
            default:   state_d = IDLE;
        endcase
    end

    // an accepted request always updates err: out-of-range sets, in-range clears
    always_comb begin
        err_d  = xfer ? ~in_range : err_q;
        incr_d = div_done ? div_quot : incr_q;
        acc_d  = en_i ? (acc_q + incr_q) : '0;
        clk_d  = en_i & acc_q[ACC_WIDTH-1];
        stb_d  = en_i & acc_q[ACC_WIDTH-1] & ~clk_q;
    end

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state_q <= IDLE;
            incr_q  <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            clk_q   <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            incr_q  <= incr_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            clk_q   <= clk_d;
            stb_q   <= stb_d;
        end
    end

    assign gen_clk_o = clk_q;
    assign gen_stb_o = stb_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_clock_gen.sv
// Directed bench for clock_gen: increments checked through a scoreboard on each
// DIV->RUN update, output waveforms/flags checked inline against hand values.
module tb_clock_gen;
    import clock_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        vld = 1'b0;
    logic [31:0] val = '0;
    logic        rdy, gclk, gstb, err;

    clock_gen #(.CLK_MHZ(100), .ACC_WIDTH(32)) dut (
        .clk_i     (clk),
        .a_rst_n_i (rst_n),
        .en_i      (en),
        .freq_val_i(val),
        .freq_vld_i(vld),
        .freq_rdy_o(rdy),
        .gen_clk_o (gclk),
        .gen_stb_o (gstb),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef CLOCK_GEN_ROUND_EN
    localparam logic [31:0] INCR_1M = 32'h028F_5C29;
`else
    localparam logic [31:0] INCR_1M = 32'h028F_5C28;
`endif

    typedef struct {
        string       name;
        logic [31:0] incr;
        longint      t;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: every DIV->RUN transition is one increment update
    clock_gen_state_t prev_st = IDLE;
    exp_t             e;
    always @(negedge clk) begin
        if (prev_st == DIV && dut.state_q == RUN) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_update: got incr 0x%0h expected none", dut.incr_q);
            end else begin
                e = sbq.pop_front();
                check({e.name, "_incr"}, 64'(dut.incr_q), 64'(e.incr));
                check({e.name, "_latency"}, 64'(cyc - e.t), 64'd33);
            end
        end
        prev_st = dut.state_q;
    end

    task automatic send(input string name, input logic [31:0] f, input logic push,
                        input logic [31:0] exp_incr);
        exp_t x;
        @(negedge clk);
        check({name, "_rdy"}, 64'(rdy), 64'd1);
        vld = 1'b1;
        val = f;
        @(posedge clk);
        #1;
        vld = 1'b0;
        val = $urandom;
        if (push) begin
            x.name = name;
            x.incr = exp_incr;
            x.t    = cyc;
            sbq.push_back(x);
        end
    endtask

    task automatic wait_run(input string name);
        int n = 0;
        while (dut.state_q != RUN && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no RUN within 200 cycles, required RUN", name);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic window(input int n, output int highs, output int stbs, output int misalign);
        logic prev;
        prev = gclk;
        highs = 0; stbs = 0; misalign = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            highs += int'(gclk);
            stbs  += int'(gstb);
            if (gstb !== (gclk & ~prev)) misalign++;
            prev = gclk;
        end
    endtask

    int h, s, m, nb;

    initial begin
        #12;
        check("reset_gen_clk", 64'(gclk), 64'd0);
        check("reset_gen_stb", 64'(gstb), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_rdy", 64'(rdy), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // 25 MHz: period 4
        send("f25M", 32'd25_000_000, 1'b1, 32'h4000_0000);
        wait_run("f25M");
        window(40, h, s, m);
        check("f25M_highs", 64'(h), 64'd20);
        check("f25M_stbs", 64'(s), 64'd10);
        check("f25M_align", 64'(m), 64'd0);

        // Nyquist: toggle every cycle
        send("f50M", 32'd50_000_000, 1'b1, 32'h8000_0000);
        check("f50M_err", 64'(err), 64'd0);
        wait_run("f50M");
        window(40, h, s, m);
        check("f50M_highs", 64'(h), 64'd20);
        check("f50M_stbs", 64'(s), 64'd20);

        // one above Nyquist: dropped, sticky error, rate unchanged
        send("f50M1", 32'd50_000_001, 1'b0, 32'h0);
        check("f50M1_err", 64'(err), 64'd1);
        check("f50M1_stay_run", 64'(dut.state_q), 64'(RUN));
        check("f50M1_incr_kept", 64'(dut.incr_q), 64'h8000_0000);
        window(40, h, s, m);
        check("f50M1_highs", 64'(h), 64'd20);
        check("f50M1_stbs", 64'(s), 64'd20);

        // 1 MHz clears error; a second request during DIV must be refused
        send("f1M", 32'd1_000_000, 1'b1, INCR_1M);
        check("f1M_err_clear", 64'(err), 64'd0);
        check("f1M_rdy_div", 64'(rdy), 64'd0);
        nb = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rdy !== 1'b0) nb++;
            vld = 1'b1;
            val = 32'd30_000_000;
        end
        @(negedge clk);
        vld = 1'b0;
        check("f1M_busy_refuse", 64'(nb), 64'd0);
        wait_run("f1M");
        window(50_000, h, s, m);
        total++;
        if (s < 499 || s > 501) begin
            bad++;
            $display("FAIL f1M_rate: got %0d strobes expected 499..501", s);
        end
        check("f1M_align", 64'(m), 64'd0);

        // disable: outputs low, division still runs; freq 0 keeps outputs low
        @(negedge clk);
        en = 1'b0;
        window(10, h, s, m);
        check("dis_highs", 64'(h), 64'd0);
        check("dis_stbs", 64'(s), 64'd0);
        check("dis_acc", 64'(dut.acc_q), 64'd0);
        send("f0", 32'd0, 1'b1, 32'h0);
        wait_run("f0");
        en = 1'b1;
        window(20, h, s, m);
        check("f0_highs", 64'(h), 64'd0);
        check("f0_stbs", 64'(s), 64'd0);

        // reset in the middle of a division
        send("f50Mb", 32'd50_000_000, 1'b1, 32'h8000_0000);
        wait_run("f50Mb");
        send("f1Mabort", 32'd1_000_000, 1'b1, INCR_1M);
        repeat (10) @(negedge clk);
        check("abort_in_div", 64'(dut.state_q), 64'(DIV));
        if (gclk !== 1'b1) @(negedge clk);
        check("abort_gclk_pre", 64'(gclk), 64'd1);
        rst_n = 1'b0;
        #1;
        sbq.delete();
        check("abort_gclk", 64'(gclk), 64'd0);
        check("abort_gstb", 64'(gstb), 64'd0);
        check("abort_err", 64'(err), 64'd0);
        check("abort_rdy", 64'(rdy), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_state", 64'(dut.state_q), 64'(IDLE));
        check("abort_incr", 64'(dut.incr_q), 64'd0);
        check("abort_rdy_post", 64'(rdy), 64'd1);
        repeat (40) @(negedge clk);
        check("sb_empty", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
